mult8s_share_arbiter: RTL

Shares one signed 8x8 `mult8s_normal_ripple` multiplier among `NUM_REQ` requesters with round-robin arbitration. The multiplier sits in a two-stage registered pipeline: operand registers, then product register. The pipeline carries a requester tag and applies valid/ready backpressure on both sides. It is the issue/return point for every block that needs a signed 8-bit multiply but does not justify a private multiplier.

---
 rtl/mult8s_share_arbiter_pkg.sv | 22 ++
 rtl/mult8s_normal_ripple.sv | 23 ++
 rtl/mult8s_share_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mult8s_share_arbiter_pkg.sv
// Shared types and widths for the round-robin shared signed 8x8 multiplier.
// Package name is mult_arb_pkg; imported by mult8s_share_arbiter.
package mult_arb_pkg;

  localparam int OPND_W      = 8;
  localparam int PROD_W      = 16;
  localparam int NUM_REQ_MAX = 8;
  localparam int ID_W_MAX    = $clog2(NUM_REQ_MAX);

  // Tags are stored at the widest legal width; the top uses the low ID_W bits.
  typedef struct packed {
    logic signed [OPND_W-1:0] multiplicand;
    logic signed [OPND_W-1:0] multiplier;
    logic [ID_W_MAX-1:0]      id;
  } mult_req_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] product;
    logic [ID_W_MAX-1:0]      id;
  } mult_rsp_t;

endpackage

// File: rtl/mult8s_normal_ripple.sv
// Combinational signed 8x8 -> 16 multiplier built from sign-extended
// partial-product rows accumulated in sequence.
module mult8s_normal_ripple (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] a_ext;
  logic [15:0] acc;

  // Bit 7 of b carries weight -128, so its row is subtracted rather than added.
  always_comb begin
    a_ext = {{8{a[7]}}, a};
    acc   = '0;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) acc = acc + (a_ext << i);
    end
    if (b[7]) acc = acc - (a_ext << 7);
    p = acc;
  end

endmodule

// File: rtl/mult8s_share_arbiter.sv
// Round-robin shared signed multiplier: operand stage, multiply, product stage.
// Optional perf counters (perf_issued, perf_stall, perf_clr) under MULT_ARB_PERF_EN.
module mult8s_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*OPND_W-1:0]   req_multiplicand,
  input  logic [NUM_REQ*OPND_W-1:0]   req_multiplier,
`ifdef MULT_ARB_PERF_EN
  input  logic                        perf_clr,
  output logic [31:0]                 perf_issued,
  output logic [31:0]                 perf_stall,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PROD_W-1:0]           out_product,
  output logic [ID_W-1:0]             out_id
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a valid source holds its payload until that edge.

  logic              s1_valid;
  logic              s2_valid;
  mult_req_t         s1;
  mult_rsp_t         s2;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   next_ptr;
  logic              s1_adv;
  logic              s2_adv;
  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;
  logic [PROD_W-1:0] prod;
  logic              unused_id_bits;

  // First valid requester at or after ptr, wrapping; MSB of result is "found".
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] r;
    int            idx;
    r = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!r[ID_W] && valid[idx]) r = {1'b1, ID_W'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    s2_adv = !s2_valid || out_ready;
    s1_adv = !s1_valid || s2_adv;
    {grant_any, grant_idx} = rr_pick(req_valid, rr_ptr);
    req_ready = '0;
    if (rst_n && grant_any && s1_adv) req_ready = NUM_REQ'(1) << grant_idx;
    accept = |(req_valid & req_ready);
    next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      rr_ptr   <= '0;
      s2       <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        rr_ptr   <= next_ptr;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_adv) begin
        s2_valid   <= s1_valid;
        s2.product <= prod;
        s2.id      <= s1.id;
      end
    end
  end

  // Operand stage payload is only meaningful while s1_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1.multiplicand <= req_multiplicand[grant_idx*OPND_W +: OPND_W];
      s1.multiplier   <= req_multiplier[grant_idx*OPND_W +: OPND_W];
      s1.id           <= ID_W_MAX'(grant_idx);
    end
  end

  mult8s_normal_ripple u_mult (
    .a (s1.multiplicand),
    .b (s1.multiplier),
    .p (prod)
  );

  assign out_valid      = s2_valid;
  assign out_product    = s2.product;
  assign out_id         = s2.id[ID_W-1:0];
  assign unused_id_bits = ^s2.id;

`ifdef MULT_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (perf_clr) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept) perf_issued <= perf_issued + 32'd1;
      if (s2_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
